fp_pack: RTL and testbench

- Inverse of the FP field-extraction stage: reassembles sign, biased exponent and an unnormalised wide mantissa into an IEEE-754 single-precision word.
- Sits at the back end of the FP adder, after the add/subtract datapath.
- Multi-cycle: iterative normalisation (one bit per cycle), then round-to-nearest-even, then pack with overflow/underflow handling.
- Valid/ready handshake on both sides.

---
 rtl/fp_pack.sv | 174 +++++++++++++++++
 tb/tb_fp_pack.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_pack.sv
// fp_pack: normalises, rounds (RNE) and packs {sign, exponent, wide mantissa} into IEEE-754 single.
// Optional macro FP_PACK_DENORM_EN produces subnormals instead of flushing tiny results to zero.
module fp_pack #(
  parameter int EXP_W = 10,
  parameter int GRS_W = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign,
  input  logic signed [EXP_W-1:0] exponent,
  input  logic [24+GRS_W:0]       mantissa,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             result,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact
);

  localparam int MW = 25 + GRS_W;
  // Two spare exponent bits absorb the carry-shift and rounding increments without wrapping.
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] XZERO   = '0;
  localparam logic signed [XW-1:0] XONE    = XW'(1);
  localparam logic signed [XW-1:0] EXP_SAT = XW'(255);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic [MW-1:0]          mant_q, mant_d;
  logic [31:0]            result_q, result_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   inexact_q, inexact_d;

  logic [24:0]            rnd_sum;
  logic                   rnd_hid;
  logic                   rnd_grs;
  logic signed [XW-1:0]   rnd_exp;

  function automatic logic [MW-1:0] shr_sticky(input logic [MW-1:0] m);
    return {1'b0, m[MW-1:2], m[1] | m[0]};
  endfunction

  // {hidden, fraction} plus the RNE increment; bit 24 is the carry out of the hidden bit.
  function automatic logic [24:0] rne_sum(input logic [MW-2:0] m);
    logic inc;
    inc = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[MW-2:3]} + 25'(inc);
  endfunction

  // On a carry out of the hidden bit the low 23 bits are already zero.
  assign rnd_sum = rne_sum(mant_q[MW-2:0]);
  assign rnd_hid = rnd_sum[24] | rnd_sum[23];
  assign rnd_grs = |mant_q[2:0];
  assign rnd_exp = rnd_sum[24] ? exp_q + XONE : exp_q;

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sign;
          exp_d   = {{2{exponent[EXP_W-1]}}, exponent};
          mant_d  = mantissa;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          result_d    = {sign_q, 31'b0};
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          inexact_d   = 1'b0;
          state_d     = DONE;
        end
`ifdef FP_PACK_DENORM_EN
        else if (exp_q < XONE) begin
          mant_d = shr_sticky(mant_q);
          exp_d  = exp_q + XONE;
        end
`endif
        else if (mant_q[MW-1]) begin
          mant_d  = shr_sticky(mant_q);
          exp_d   = exp_q + XONE;
          state_d = ROUND;
        end else if (!mant_q[MW-2] && (exp_q > XONE)) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - XONE;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d     = DONE;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        inexact_d   = rnd_grs;
        if (rnd_exp >= EXP_SAT) begin
          result_d   = {sign_q, 8'hFF, 23'b0};
          overflow_d = 1'b1;
          inexact_d  = 1'b1;
        end
`ifdef FP_PACK_DENORM_EN
        else if (!rnd_hid) begin
          result_d    = {sign_q, 8'h00, rnd_sum[22:0]};
          underflow_d = rnd_grs;
        end
`else
        else if ((rnd_exp <= XZERO) || !rnd_hid) begin
          result_d    = {sign_q, 31'b0};
          underflow_d = 1'b1;
          inexact_d   = 1'b1;
        end
`endif
        else begin
          result_d = {sign_q, rnd_exp[7:0], rnd_sum[22:0]};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          result_d    = '0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          inexact_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
    end
  end

  // Working datapath registers are only meaningful after a capture in IDLE.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    mant_q <= mant_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_pack.sv
// Self-checking bench for fp_pack: directed cases plus randomized operands against a numeric reference.
module tb_fp_pack;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic              sign;
  logic signed [9:0] exponent;
  logic [27:0]       mantissa;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              overflow;
  logic              underflow;
  logic              inexact;

  int n_chk  = 0;
  int n_pass = 0;

  fp_pack #(.EXP_W(10), .GRS_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .exponent  (exponent),
    .mantissa  (mantissa),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, want);
  endtask

  // Reference computed from the value: normalise by msb position, round on the integer significand.
  task automatic ref_model(input logic s, input int e_in, input logic [27:0] mant,
                           output logic [31:0] r, output logic [2:0] f, output int lat);
    logic [63:0] m;
    logic [63:0] sig;
    int e, p, l, shifts;
    int rem;
    logic ov, uf, ix, hid;
    m = 64'(mant); e = e_in; shifts = 0; ov = 0; uf = 0; ix = 0;
    if (mant == 0) begin
      r = {s, 31'b0}; f = 3'b000; lat = 1;
      return;
    end
`ifdef FP_PACK_DENORM_EN
    if (e < 1) begin
      int k;
      logic lost;
      k = 1 - e;
      lost = (k >= 28) ? 1'b1 : ((m & ((64'd1 << k) - 1)) != 0);
      m = (k >= 28) ? 64'd0 : (m >> k);
      m = m | 64'(lost);
      e = 1;
      shifts += k;
    end
`endif
    if (m[27]) begin
      m = (m >> 1) | (m & 64'd1);
      e = e + 1;
    end else begin
      p = $clog2(m + 1) - 1;
      l = 26 - p;
      if (l > e - 1) l = (e - 1 > 0) ? e - 1 : 0;
      m = m << l;
      e = e - l;
      shifts += l;
    end
    sig = m >> 3;
    rem = int'(m & 64'd7);
    ix  = (rem != 0);
    if (rem > 4 || (rem == 4 && sig[0])) sig = sig + 1;
    if (sig == 64'd1 << 24) begin
      sig = 64'd1 << 23;
      e = e + 1;
    end
    hid = (sig >= (64'd1 << 23));
    if (e >= 255) begin
      r = {s, 8'hFF, 23'b0}; ov = 1; ix = 1;
    end
`ifdef FP_PACK_DENORM_EN
    else if (!hid) begin
      r = {s, 8'h00, sig[22:0]}; uf = ix;
    end
`else
    else if (e <= 0 || !hid) begin
      r = {s, 31'b0}; uf = 1; ix = 1;
    end
`endif
    else begin
      r = {s, e[7:0], sig[22:0]};
    end
    f = {ov, uf, ix};
    lat = shifts + 2;
  endtask

  task automatic do_op(input logic s, input int e, input logic [27:0] m, input int hold,
                       input logic [31:0] wr, input logic [2:0] wf, input int wl);
    int lat;
    sign = s; exponent = e[9:0]; mantissa = m; in_valid = 1'b1;
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(wl));
    chk("result", result, wr);
    chk("flags", {29'b0, overflow, underflow, inexact}, {29'b0, wf});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_result", result, wr);
      chk("hold_busy", {30'b0, in_ready, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_hs", {30'b0, in_ready, out_valid}, 32'd2);
    chk("release_clear", {result[31:3] | 29'b0, result[2:0] | {overflow, underflow, inexact}}, 32'd0);
  endtask

  task automatic rand_op(input logic s, input int e, input logic [27:0] m, input int hold);
    logic [31:0] wr;
    logic [2:0]  wf;
    int          wl;
    ref_model(s, e, m, wr, wf, wl);
    do_op(s, e, m, hold, wr, wf, wl);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int stale;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign = 1'b0; exponent = '0; mantissa = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hs", {30'b0, in_ready, out_valid}, 32'd2);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {29'b0, overflow, underflow, inexact}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op(1'b0, 127, 28'h4000000, 0, 32'h3F800000, 3'b000, 2);
    do_op(1'b0, 127, 28'h8000000, 0, 32'h40000000, 3'b000, 2);
    do_op(1'b0, 127, 28'h0800000, 1, 32'h3E000000, 3'b000, 5);
    do_op(1'b0, 127, 28'h4000004, 0, 32'h3F800000, 3'b001, 2);
    do_op(1'b0, 127, 28'h400000C, 0, 32'h3F800002, 3'b001, 2);
    do_op(1'b0, 254, 28'h7FFFFFC, 4, 32'h7F800000, 3'b101, 2);
    do_op(1'b1, 127, 28'h0000000, 0, 32'h80000000, 3'b000, 1);
`ifdef FP_PACK_DENORM_EN
    do_op(1'b0, 1, 28'h2000000, 0, 32'h00400000, 3'b000, 2);
`else
    do_op(1'b0, 1, 28'h2000000, 0, 32'h00000000, 3'b011, 2);
`endif

    // Reset in the middle of a long left-normalisation.
    sign = 1'b0; exponent = 10'sd127; mantissa = 28'h0000100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midnorm_reset_hs", {30'b0, in_ready, out_valid}, 32'd2);
    chk("midnorm_reset_result", result, 32'd0);
    reset_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("no_stale_result", 32'(stale), 32'd0);
    do_op(1'b1, 130, 28'h4000000, 0, 32'hC1000000, 3'b000, 2);

    for (int i = 0; i < 200; i++) begin
      logic [27:0] m;
      int e;
      m = 28'($urandom) >> $urandom_range(0, 27);
      if ($urandom_range(0, 15) == 0) m = '0;
      e = $urandom_range(0, 339) - 40;
      if ($urandom_range(0, 7) == 0) e = $urandom_range(250, 256);
      rand_op(1'($urandom), e, m, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
